ram_rr_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of one single_port_ram (synchronous write, registered-address read).
- Accepts at most one valid/ready request per cycle and registers it onto the RAM port.
- Returns read data to the issuing requester with a fixed 2-cycle latency.
- Lets two independent engines share one single-port memory without collisions.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 15 +
 rtl/single_port_ram.sv | 24 ++
 rtl/ram_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_ram_rr_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-requester RAM arbiter: requester ids and stats counter sizing.
package ram_arb_pkg;
    localparam int NUM_REQ  = 2;
    localparam int REQ_ID_W = 1;
    typedef logic [REQ_ID_W-1:0] req_id_t;
    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    localparam int STATS_W = 16;
    localparam logic [STATS_W-1:0] STATS_MAX = {STATS_W{1'b1}};
    localparam logic [STATS_W-1:0] STATS_ONE = {{(STATS_W-1){1'b0}}, 1'b1};

    // Saturating increment used by all stats counters.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == STATS_MAX) ? v : v + STATS_ONE;
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant: on contention the requester that did not win last is chosen.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  req_id_t            last_grant,
    output logic [NUM_REQ-1:0] grant
);
    always_comb begin
        grant = valid;
        if (&valid) begin
            grant = (last_grant == REQ0) ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/single_port_ram.sv
// Single-port RAM: synchronous write, address registered on the clock, data read from the registered address.
module single_port_ram #(
    parameter int addr_width = 6,
    parameter int data_width = 8,
    parameter int depth      = 64
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] addr,
    input  logic [data_width-1:0] data,
    output logic [data_width-1:0] q
);
    logic [data_width-1:0] mem_q [depth];
    logic [addr_width-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= data;
        end
        addr_q <= addr;
    end

    assign q = mem_q[addr_q];
endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port RAM between two requesters, 2-cycle read latency.
// Optional grant/conflict counters are enabled with the RAM_RR_ARBITER_STATS_EN macro.
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int addr_width = 6,
    parameter int data_width = 8,
    parameter int depth      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic                  r0_we,
    input  logic [addr_width-1:0] r0_addr,
    input  logic [data_width-1:0] r0_wdata,
    output logic                  r0_rvalid,
    output logic [data_width-1:0] r0_rdata,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic                  r1_we,
    input  logic [addr_width-1:0] r1_addr,
    input  logic [data_width-1:0] r1_wdata,
    output logic                  r1_rvalid,
    output logic [data_width-1:0] r1_rdata,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_data,
    input  logic [data_width-1:0] ram_q
`ifdef RAM_RR_ARBITER_STATS_EN
    ,
    output logic [STATS_W-1:0]    r0_grants,
    output logic [STATS_W-1:0]    r1_grants,
    output logic [STATS_W-1:0]    conflict_cnt
`endif
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    grant;
    logic                  accept;
    req_id_t               sel_src;
    logic                  sel_we;
    logic [addr_width-1:0] sel_addr;
    logic [data_width-1:0] sel_data;

    req_id_t               last_grant_q, last_grant_d;
    logic                  ram_we_q, ram_we_d;
    logic [addr_width-1:0] ram_addr_q, ram_addr_d;
    logic [data_width-1:0] ram_data_q, ram_data_d;
    logic                  valid_a_q, valid_a_d;
    logic                  is_read_a_q, is_read_a_d;
    req_id_t               src_a_q, src_a_d;
    logic                  valid_b_q, valid_b_d;
    req_id_t               src_b_q, src_b_d;

    // Masking with rst keeps ready low while reset is asserted.
    assign req_valid = {r1_valid, r0_valid} & {NUM_REQ{~rst}};

    rr_arb2 u_rr_arb2 (
        .valid      (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign r0_ready = grant[0];
    assign r1_ready = grant[1];
    assign accept   = |grant;
    assign sel_src  = grant[1] ? REQ1 : REQ0;
    assign sel_we   = grant[1] ? r1_we    : r0_we;
    assign sel_addr = grant[1] ? r1_addr  : r0_addr;
    assign sel_data = grant[1] ? r1_wdata : r0_wdata;

    always_comb begin
        last_grant_d = accept ? sel_src : last_grant_q;
        ram_we_d     = accept & sel_we;
        ram_addr_d   = accept ? sel_addr : ram_addr_q;
        ram_data_d   = accept ? sel_data : ram_data_q;
        valid_a_d    = accept;
        is_read_a_d  = ~sel_we;
        src_a_d      = sel_src;
        valid_b_d    = valid_a_q & is_read_a_q;
        src_b_d      = src_a_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= REQ1;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            valid_a_q    <= 1'b0;
            is_read_a_q  <= 1'b0;
            src_a_q      <= REQ0;
            valid_b_q    <= 1'b0;
            src_b_q      <= REQ0;
        end else begin
            last_grant_q <= last_grant_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            valid_a_q    <= valid_a_d;
            is_read_a_q  <= is_read_a_d;
            src_a_q      <= src_a_d;
            valid_b_q    <= valid_b_d;
            src_b_q      <= src_b_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign r0_rvalid = valid_b_q & (src_b_q == REQ0);
    assign r1_rvalid = valid_b_q & (src_b_q == REQ1);
    assign r0_rdata  = ram_q;
    assign r1_rdata  = ram_q;

`ifdef RAM_RR_ARBITER_STATS_EN
    logic [STATS_W-1:0] grant_cnt_q [NUM_REQ];
    logic [STATS_W-1:0] grant_cnt_d [NUM_REQ];
    logic [STATS_W-1:0] conflict_cnt_q, conflict_cnt_d;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
        always_comb begin
            grant_cnt_d[gi] = grant[gi] ? sat_inc(grant_cnt_q[gi]) : grant_cnt_q[gi];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                grant_cnt_q[gi] <= '0;
            end else begin
                grant_cnt_q[gi] <= grant_cnt_d[gi];
            end
        end
    end

    always_comb begin
        conflict_cnt_d = (&req_valid) ? sat_inc(conflict_cnt_q) : conflict_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign r0_grants    = grant_cnt_q[0];
    assign r1_grants    = grant_cnt_q[1];
    assign conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed self-checking bench for ram_rr_arbiter with a single_port_ram beside it.
module tb_ram_rr_arbiter;
    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_valid, r0_ready, r0_we, r0_rvalid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_valid, r1_ready, r1_we, r1_rvalid;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data, ram_q;
`ifdef RAM_RR_ARBITER_STATS_EN
    logic [15:0]   r0_grants, r1_grants, conflict_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_rr_arbiter #(.addr_width(AW), .data_width(DW), .depth(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_we     (r0_we),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_rvalid (r0_rvalid),
        .r0_rdata  (r0_rdata),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_we     (r1_we),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_rvalid (r1_rvalid),
        .r1_rdata  (r1_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_q     (ram_q)
`ifdef RAM_RR_ARBITER_STATS_EN
        ,
        .r0_grants    (r0_grants),
        .r1_grants    (r1_grants),
        .conflict_cnt (conflict_cnt)
`endif
    );

    single_port_ram #(.addr_width(AW), .data_width(DW), .depth(64)) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .data (ram_data),
        .q    (ram_q)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then move to the falling edge for checks.
    task automatic cyc(input logic r,
                       input logic v0, input logic we0, input int a0, input logic [DW-1:0] d0,
                       input logic v1, input logic we1, input int a1, input logic [DW-1:0] d1);
        @(posedge clk);
        #1;
        rst      = r;
        r0_valid = v0; r0_we = we0; r0_addr = AW'(a0); r0_wdata = d0;
        r1_valid = v1; r1_we = we1; r1_addr = AW'(a1); r1_wdata = d1;
        @(negedge clk);
    endtask

    task automatic check_ready(input string tag, input logic e0, input logic e1);
        check_eq({tag, "_r0_ready"}, {31'b0, r0_ready}, {31'b0, e0});
        check_eq({tag, "_r1_ready"}, {31'b0, r1_ready}, {31'b0, e1});
    endtask

    task automatic check_rvalid(input string tag, input logic e0, input logic e1);
        check_eq({tag, "_r0_rvalid"}, {31'b0, r0_rvalid}, {31'b0, e0});
        check_eq({tag, "_r1_rvalid"}, {31'b0, r1_rvalid}, {31'b0, e1});
    endtask

    initial begin
        int  i0, i1, src;
        logic g0, g1;
        rst = 1'b1;
        r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;

        // Reset for two cycles with both requesters trying to get in.
        cyc(1, 1, 1, 9, 8'h55, 1, 1, 9, 8'h66);
        check_ready("rst0", 0, 0);
        check_rvalid("rst0", 0, 0);
        cyc(1, 1, 1, 9, 8'h55, 1, 1, 9, 8'h66);
        check_ready("rst1", 0, 0);
        check_rvalid("rst1", 0, 0);
        check_eq("rst_ram_we", {31'b0, ram_we}, 0);
        check_eq("rst_ram_addr", {26'b0, ram_addr}, 0);
        check_eq("rst_ram_data", {24'b0, ram_data}, 0);
        $display("reset: checked ready/rvalid/ram port idle");

        // Preload addrs 0..3 with 10..13 under contention; r0 wins first.
        cyc(0, 1, 1, 0, 8'h10, 1, 1, 1, 8'h11);
        check_ready("pre0", 1, 0);
        $display("write r0 addr 0 data 10");
        cyc(0, 1, 1, 2, 8'h12, 1, 1, 1, 8'h11);
        check_ready("pre1", 0, 1);
        check_eq("pre1_ram_we", {31'b0, ram_we}, 1);
        check_eq("pre1_ram_addr", {26'b0, ram_addr}, 0);
        check_eq("pre1_ram_data", {24'b0, ram_data}, 32'h10);
        $display("write r1 addr 1 data 11");
        cyc(0, 1, 1, 2, 8'h12, 1, 1, 3, 8'h13);
        check_ready("pre2", 1, 0);
        $display("write r0 addr 2 data 12");
        cyc(0, 0, 0, 0, 8'h00, 1, 1, 3, 8'h13);
        check_ready("pre3", 0, 1);
        $display("write r1 addr 3 data 13");

        // r0 writes A5 to addr 5, r1 reads it back on the next accept.
        cyc(0, 1, 1, 5, 8'hA5, 0, 0, 0, 8'h00);
        check_ready("raw_w", 1, 0);
        $display("write r0 addr 5 data a5");
        cyc(0, 0, 0, 0, 8'h00, 1, 0, 5, 8'h00);
        check_ready("raw_r", 0, 1);
        check_eq("raw_ram_we_w", {31'b0, ram_we}, 1);
        cyc(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        check_rvalid("raw_lat1", 0, 0);
        check_eq("raw_ram_we_r", {31'b0, ram_we}, 0);
        check_eq("raw_ram_addr_r", {26'b0, ram_addr}, 5);
        cyc(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        check_rvalid("raw_lat2", 0, 1);
        check_eq("raw_r1_rdata", {24'b0, r1_rdata}, 32'hA5);
        $display("read r1 addr 5 -> %0h", r1_rdata);
        cyc(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        check_rvalid("raw_after", 0, 0);

        // Continuous contended reads of addrs 0..3 from both requesters.
        i0 = 0; i1 = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(0, i0 < 4, 0, i0, 8'h00, i1 < 4, 0, i1, 8'h00);
            g0 = (k < 8) && (k % 2 == 0);
            g1 = (k < 8) && (k % 2 == 1);
            check_ready($sformatf("rr%0d", k), g0, g1);
            if (k >= 2) begin
                src = (k - 2) % 2;
                check_rvalid($sformatf("rr%0d", k), src == 0, src == 1);
                check_eq($sformatf("rr%0d_rdata", k),
                         {24'b0, (src == 0) ? r0_rdata : r1_rdata}, 32'h10 + (k - 2) / 2);
                $display("read r%0d addr %0d -> %0h", src, (k - 2) / 2,
                         (src == 0) ? r0_rdata : r1_rdata);
            end
            if (g0) i0++;
            if (g1) i1++;
        end

        // r1 holds valid while r0 keeps requesting: r1 must win by the second cycle.
        cyc(0, 1, 0, 8, 8'h00, 1, 0, 9, 8'h00);
        check_ready("starve0", 1, 0);
        cyc(0, 1, 0, 10, 8'h00, 1, 0, 9, 8'h00);
        check_ready("starve1", 0, 1);
        check_eq("starve1_ram_addr", {26'b0, ram_addr}, 8);
        cyc(0, 1, 0, 10, 8'h00, 0, 0, 0, 8'h00);
        check_ready("starve2", 1, 0);
        check_eq("starve2_ram_addr", {26'b0, ram_addr}, 9);
        cyc(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        check_eq("starve3_ram_addr", {26'b0, ram_addr}, 10);
        $display("no-starvation: r1 accepted on second contended cycle");
        cyc(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);

        // r0 read of addr 7, reset one edge after the accept kills it.
        cyc(0, 1, 0, 7, 8'h00, 0, 0, 0, 8'h00);
        check_ready("mid_acc", 1, 0);
        cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        check_ready("mid_rst", 0, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        check_rvalid("mid_drop", 0, 0);
        check_eq("mid_ram_we", {31'b0, ram_we}, 0);
        cyc(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        check_rvalid("mid_drop2", 0, 0);
        check_eq("mid_ram_we2", {31'b0, ram_we}, 0);
        $display("reset mid-read: response discarded");

        // Ten contended cycles after reset: r0 first, strict alternation.
        for (int k = 0; k < 10; k++) begin
            cyc(0, 1, 0, 0, 8'h00, 1, 0, 1, 8'h00);
            check_ready($sformatf("post%0d", k), k % 2 == 0, k % 2 == 1);
        end
        cyc(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
`ifdef RAM_RR_ARBITER_STATS_EN
        check_eq("stats_r0_grants", {16'b0, r0_grants}, 5);
        check_eq("stats_r1_grants", {16'b0, r1_grants}, 5);
        check_eq("stats_conflicts", {16'b0, conflict_cnt}, 10);
        $display("stats: r0=%0d r1=%0d conflicts=%0d", r0_grants, r1_grants, conflict_cnt);
`endif
        cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
`ifdef RAM_RR_ARBITER_STATS_EN
        check_eq("stats_rst_r0", {16'b0, r0_grants}, 0);
        check_eq("stats_rst_r1", {16'b0, r1_grants}, 0);
        check_eq("stats_rst_conf", {16'b0, conflict_cnt}, 0);
        $display("stats after reset: r0=%0d r1=%0d conflicts=%0d", r0_grants, r1_grants, conflict_cnt);
`endif
        check_rvalid("final", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
